// File: rtl/npu_pkg.sv
// npu_pkg: shared constants for the NPU load path.
//   REG_*        : wr_sel region codes, also decoded by mem_top
//   *_DEF        : default region sizes (writes per region)
//   state_t      : load sequencer states
//   region_of()  : load state -> region code
//   is_byte_region(): regions carried one byte per host write
package npu_pkg;
    localparam logic [2:0] REG_IMG = 3'd0;
    localparam logic [2:0] REG_C12 = 3'd1;
    localparam logic [2:0] REG_C34 = 3'd2;
    localparam logic [2:0] REG_C5  = 3'd3;
    localparam logic [2:0] REG_D1  = 3'd4;
    localparam logic [2:0] REG_D2  = 3'd5;

    localparam int IMG_WORDS_DEF    = 224;
    localparam int CONV12_BYTES_DEF = 320;
    localparam int CONV34_BYTES_DEF = 9248;
    localparam int CONV5_BYTES_DEF  = 9248;
    localparam int DENSE1_WORDS_DEF = 4103;
    localparam int DENSE2_WORDS_DEF = 98;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IMG,
        S_C12,
        S_C34,
        S_C5,
        S_D1,
        S_D2,
        S_DONE
    } state_t;

    function automatic logic [2:0] region_of(state_t s);
        case (s)
            S_C12:   return REG_C12;
            S_C34:   return REG_C34;
            S_C5:    return REG_C5;
            S_D1:    return REG_D1;
            S_D2:    return REG_D2;
            default: return REG_IMG;
        endcase
    endfunction

    function automatic logic is_byte_region(logic [2:0] r);
        return r == REG_C12 || r == REG_C34 || r == REG_C5;
    endfunction
endpackage

// File: rtl/region_counter.sv
// region_counter: word counter within the current memory region.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : force count to 0 (start of a new load)
//   inc        : count one accepted write; wraps to 0 after the last word
//   len        : number of writes in the current region
//   count      : current region-relative address
//   last       : count is the final word of the region
module region_counter #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] len,
    output logic [W-1:0] count,
    output logic         last
);
    assign last = count == len - W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc)
            count <= last ? '0 : count + W'(1);
    end
endmodule

// File: rtl/load_sequencer.sv
// load_sequencer: steers the host write stream into the NPU memory regions
// and gates inference start until a complete model is resident.
//   clk, reset   : clock, asynchronous active-low reset
//   control_reg  : 1 = load, 2 = inference, anything else idle
//   writedata    : host data word, qualified by write
//   wr_en/wr_sel/wr_addr/wr_data : registered memory write port
//   busy         : loading in progress
//   load_done    : complete model resident
//   load_err     : sticky protocol error, cleared when a new load starts
//   start_infer  : one-cycle pulse to the compute controller
module load_sequencer
    import npu_pkg::*;
#(
    parameter int IMG_WORDS    = IMG_WORDS_DEF,
    parameter int CONV12_BYTES = CONV12_BYTES_DEF,
    parameter int CONV34_BYTES = CONV34_BYTES_DEF,
    parameter int CONV5_BYTES  = CONV5_BYTES_DEF,
    parameter int DENSE1_WORDS = DENSE1_WORDS_DEF,
    parameter int DENSE2_WORDS = DENSE2_WORDS_DEF,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       control_reg,
    input  logic [31:0]       writedata,
    input  logic              write,
    output logic              wr_en,
    output logic [2:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic              start_infer
);
    state_t            state, next_state;
    logic [ADDR_W-1:0] cnt, len;
    logic              last, loading, is_load, is_infer, accept, cnt_clr;
    logic              held, held_d, left_load, left_load_d;
    logic              done_d, err_d, start_d;
    logic [2:0]        sel;

    assign is_load  = control_reg == 32'd1;
    assign is_infer = control_reg == 32'd2;
    assign loading  = state != S_IDLE && state != S_DONE;
    // a write in the same cycle the host leaves load mode is dropped
    assign accept   = loading && is_load && write;
    assign sel      = region_of(state);

    always_comb begin
        case (state)
            S_IMG:   len = ADDR_W'(IMG_WORDS);
            S_C12:   len = ADDR_W'(CONV12_BYTES);
            S_C34:   len = ADDR_W'(CONV34_BYTES);
            S_C5:    len = ADDR_W'(CONV5_BYTES);
            S_D1:    len = ADDR_W'(DENSE1_WORDS);
            default: len = ADDR_W'(DENSE2_WORDS);
        endcase
    end

    region_counter #(.W(ADDR_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (accept),
        .len   (len),
        .count (cnt),
        .last  (last)
    );

    always_comb begin
        next_state  = state;
        cnt_clr     = 1'b0;
        done_d      = load_done;
        err_d       = load_err;
        start_d     = 1'b0;
        held_d      = 1'b0;
        left_load_d = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_load) begin
                    next_state = S_IMG;
                    cnt_clr    = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end else if (write || is_infer) begin
                    err_d = 1'b1;
                end
            end
            S_DONE: begin
                // reload only after the host has released load mode once;
                // held suppresses repeat pulses while control_reg stays 2
                left_load_d = left_load || !is_load;
                held_d      = is_infer;
                start_d     = is_infer && !held;
                if (is_load && left_load) begin
                    next_state = S_IMG;
                    cnt_clr    = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end else if (write) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                if (!is_load) begin
                    next_state = S_IDLE;
                    err_d      = 1'b1;
                    done_d     = 1'b0;
                end else if (write && last) begin
                    next_state = state == S_D2 ? S_DONE : state_t'(state + 3'd1);
                    done_d     = state == S_D2;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            held        <= 1'b0;
            left_load   <= 1'b0;
            wr_en       <= 1'b0;
            wr_sel      <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
            start_infer <= 1'b0;
        end else begin
            state       <= next_state;
            held        <= held_d;
            left_load   <= left_load_d;
            wr_en       <= accept;
            busy        <= next_state != S_IDLE && next_state != S_DONE;
            load_done   <= done_d;
            load_err    <= err_d;
            start_infer <= start_d;
            if (accept) begin
                wr_sel  <= sel;
                wr_addr <= cnt;
                wr_data <= is_byte_region(sel) ? {24'b0, writedata[7:0]} : writedata;
            end
        end
    end
endmodule
